// File: rtl/line_mem_pkg.sv
// ---------------------------------------------------------------------------
// line_mem_pkg
// Shared constants and types for the line memory responder.
//   LINE_W   : width of one stored line in bits
//   OFFSET_W : byte-offset bits inside a line (ignored for indexing)
//   ADDR_W   : byte address width seen by the responder
//   CNT_W    : width of the latency down-counter (covers LATENCY 1..255)
//   state_t  : responder handshake states
// ---------------------------------------------------------------------------
package line_mem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/line_mem_array.sv
// ---------------------------------------------------------------------------
// line_mem_array
// Synchronous single-port line storage. One access per cycle: a write
// updates the addressed line, a read loads rdata_o on the same edge.
// rdata_o only changes on reads, so it keeps the last read line across
// writes and idle cycles. No reset: contents survive reset by design, and
// the array is visible hierarchically as 'memory' for preload and flush.
//
// Ports:
//   clk_i   : clock
//   en_i    : access enable for this cycle
//   we_i    : 1 = write, 0 = read (qualified by en_i)
//   addr_i  : line index
//   wdata_i : line write data
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] memory [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        memory[addr_i] <= wdata_i;
      end else begin
        rdata_o <= memory[addr_i];
      end
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// ---------------------------------------------------------------------------
// line_mem_responder
// Fixed-latency line memory target. A request seen in IDLE is captured,
// a down-counter runs for LATENCY cycles, and on the edge entering ACK the
// line is written or read. ack_o pulses for the single ACK cycle, after
// which the FSM always returns to IDLE, so back-to-back requests complete
// every LATENCY+2 cycles.
//
// Ports:
//   clk_i      : clock, all state changes on the rising edge
//   rst_i      : asynchronous active-low reset (storage is not cleared)
//   addr_i     : byte address; line index = addr_i[5 +: log2(DEPTH)]
//   data_i     : write line data
//   enable_i   : request valid, held until ack_o
//   write_i    : 1 = write line, 0 = read line
//   ack_o      : one-cycle completion pulse
//   data_o     : last read line; 0 after reset until the first read
//   rd_count_o : completed reads  (only with LINE_MEM_STATS_EN)
//   wr_count_o : completed writes (only with LINE_MEM_STATS_EN)
//
// Optional feature macro: LINE_MEM_STATS_EN adds the read/write counters.
// ---------------------------------------------------------------------------
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [IDX_W-1:0]   r_index;
  logic [LINE_W-1:0]  r_wdata;
  logic               r_write;
  logic               r_ack;
  logic               r_rd_valid;

  logic               w_mem_en;
  logic [LINE_W-1:0]  w_rdata;
  logic               w_unused_addr;

  // Only the index field selects a line; everything else aliases.
  assign w_unused_addr = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  // The memory access happens on the BUSY edge that moves to ACK, so the
  // write commits and the read data lands exactly as ack_o rises.
  assign w_mem_en = (r_state == BUSY) && (r_count == '0);

  line_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (w_mem_en),
    .we_i    (r_write),
    .addr_i  (r_index),
    .wdata_i (r_wdata),
    .rdata_o (w_rdata)
  );

  // Handshake FSM. Inputs are only looked at in IDLE, so anything the
  // initiator changes during BUSY or ACK has no effect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_index    <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_ack      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable_i) begin
            r_index <= addr_i[OFFSET_W +: IDX_W];
            r_wdata <= data_i;
            r_write <= write_i;
            r_count <= CNT_W'(LATENCY - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_count == '0) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            if (!r_write) begin
              r_rd_valid <= 1'b1;
            end
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack_o = r_ack;

  // The array read register has no reset, so data_o is masked to zero
  // until the first read after reset has refreshed it.
  assign data_o = r_rd_valid ? w_rdata : '0;

`ifdef LINE_MEM_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  // Counters step on the same edge that raises ack_o, so the new value is
  // visible during the ack cycle. They wrap naturally at 32 bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_mem_en) begin
      if (r_write) begin
        r_wr_count <= r_wr_count + 32'd1;
      end else begin
        r_rd_count <= r_rd_count + 32'd1;
      end
    end
  end

  assign rd_count_o = r_rd_count;
  assign wr_count_o = r_wr_count;
`endif

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 10, meaning cycles from request capture to ack_o (legal range 1..255).
REQ-002 SHALL have parameter DEPTH, default 512, meaning number of 256-bit lines stored (power of two).
REQ-003 SHALL have port clk_i  input  1  clock; one clock domain; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port addr_i  input  32  byte address; line index = addr_i[5+log2(DEPTH)-1:5].
REQ-006 SHALL have port data_i  input  256  write line data.
REQ-007 SHALL have port enable_i  input  1  request valid, held by initiator until ack_o seen.
REQ-008 SHALL have port write_i  input  1  1=write line, 0=read line; qualified by enable_i.
REQ-009 SHALL have port ack_o  output  1  single-cycle completion pulse.
REQ-010 SHALL have port data_o  output  256  read line data, valid while ack_o=1 for reads.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, ACK.
REQ-012 In IDLE with enable_i=1, SHALL capture addr_i, data_i and write_i, load the delay counter with LATENCY-1, and go to BUSY.
REQ-013 In BUSY, SHALL decrement the counter each cycle and go to ACK on the edge where the counter is 0; with LATENCY=1 it SHALL go to ACK on the first BUSY edge.
REQ-014 SHALL assert ack_o exactly LATENCY cycles after the capture edge, for exactly one cycle, in state ACK only.
REQ-015 On the edge entering ACK, SHALL commit captured write data to the addressed line, or load data_o from the addressed line for a read.
REQ-016 SHALL hold data_o unchanged across write transactions and between transactions.
REQ-017 ACK SHALL go to IDLE unconditionally; enable_i still high in the ACK cycle SHALL NOT start a new request.
REQ-018 A request seen in IDLE in the cycle after ACK SHALL be accepted; back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-019 enable_i, addr_i, data_i and write_i changing during BUSY SHALL be ignored; the captured request SHALL complete and pulse ack_o.
REQ-020 Address bits above the index field and bits [4:0] SHALL be ignored; out-of-range addresses alias modulo DEPTH.

Reset
REQ-021 rst_i=0 SHALL immediately force state IDLE, ack_o=0, data_o=0 and counter=0.
REQ-022 Reset mid-transaction SHALL abort the transaction without an ack_o pulse; a write not yet committed SHALL be lost.
REQ-023 Reset SHALL NOT clear the line storage array.

Configuration
REQ-024 Macro LINE_MEM_STATS_EN SHALL add output ports rd_count_o (32) and wr_count_o (32), each reset to 0 and incremented on every ack_o of a read or write respectively, wrapping 0xFFFFFFFF->0.
REQ-025 Without LINE_MEM_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package line_mem_pkg SHALL hold LINE_W=256, OFFSET_W=5, and the FSM state typedef (IDLE/BUSY/ACK).
REQ-027 Line storage SHALL be a sub-module line_mem_array (synchronous single-port, one read or write per cycle, no reset), exposing the storage as hierarchical array memory for bench preload and flush.

Verification
REQ-028 Preload line 0 = 256'h5; read addr 0x00 at LATENCY=10 -> ack_o high in exactly cycle 10 after capture, data_o=256'h5, ack width 1.
REQ-029 Write addr 0x20 data 256'hAB, then read 0x20 -> second ack returns 256'hAB; data_o unchanged (256'h5) during the write ack.
REQ-030 Hold enable_i high continuously for two reads -> acks LATENCY+2 cycles apart; no request accepted during the ACK cycle.
REQ-031 Assert rst_i=0 at cycle 4 of a write to 0x40 -> no ack_o, ack_o=0 and data_o=0, line 2 unchanged.
REQ-032 LATENCY=1, read 0x4000 with DEPTH=512 -> aliases to line 0, ack_o one cycle after capture.
REQ-033 With LINE_MEM_STATS_EN: 3 reads + 2 writes -> rd_count_o=3, wr_count_o=2; after reset both 0.
